// File: rtl/voter_pkg.sv
// voter_pkg: types and constants shared by the voting-session block.
//   state_t    : session FSM states (IDLE, COLLECT, RESULT)
//   RES_*      : one-hot verdict encodings, [2] reject, [1] tie, [0] accept
package voter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

    localparam logic [2:0] RES_REJECT = 3'b100;
    localparam logic [2:0] RES_TIE    = 3'b010;
    localparam logic [2:0] RES_ACCEPT = 3'b001;
    localparam logic [2:0] RES_NONE   = 3'b000;

endpackage

// File: rtl/voter_tally.sv
// voter_tally: combinational tally and verdict for N_VOTERS ballots.
// Generalises the old fixed 4-input case-table voter.
//   ballots   in  N_VOTERS  per-voter ballot (1 = yes)
//   mask      in  N_VOTERS  per-voter "has voted" flag
//   yes_cnt   out CNT_W     number of counted yes ballots
//   voted_cnt out CNT_W     number of voters that voted
//   verdict   out 3         one-hot reject / tie / accept
// Voters whose mask bit is clear count as "no".
module voter_tally
    import voter_pkg::*;
#(
    parameter int N_VOTERS = 4,
    parameter int CNT_W    = $clog2(N_VOTERS + 1)
) (
    input  logic [N_VOTERS-1:0] ballots,
    input  logic [N_VOTERS-1:0] mask,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    voted_cnt,
    output logic [2:0]          verdict
);

    // 2*Y is compared against N one bit wider than the tally, so it cannot overflow.
    localparam logic [CNT_W:0] N_EXT = (CNT_W + 1)'(N_VOTERS);

    logic [CNT_W:0] two_y;

    always_comb begin
        yes_cnt   = '0;
        voted_cnt = '0;
        for (int k = 0; k < N_VOTERS; k++) begin
            yes_cnt   = yes_cnt + CNT_W'(ballots[k] & mask[k]);
            voted_cnt = voted_cnt + CNT_W'(mask[k]);
        end
    end

    always_comb begin
        two_y = {yes_cnt, 1'b0};
        if (two_y < N_EXT) begin
            verdict = RES_REJECT;
        end else if (two_y == N_EXT) begin
            verdict = RES_TIE;
        end else begin
            verdict = RES_ACCEPT;
        end
    end

endmodule

// File: rtl/voter_session.sv
// voter_session: timed voting sessions for N_VOTERS voters, one ballot per
// voter per session, with a registered one-hot verdict and tallies.
//   clk, rst_n  in   clock, synchronous active-low reset
//   start       in   opens a session (honoured only in IDLE)
//   vote_valid  in   N_VOTERS  bit k: voter k casts a ballot this cycle
//   vote_val    in   N_VOTERS  bit k: voter k's ballot (1 = yes)
//   busy        out  high in COLLECT and RESULT
//   done        out  one-cycle pulse in RESULT
//   result      out  3  one-hot verdict [2] reject, [1] tie, [0] accept
//   yes_cnt     out  CNT_W  yes ballots in the last closed session
//   voted_cnt   out  CNT_W  ballots cast in the last closed session
//   dbg_state   out  current FSM state
//
// Ballot semantics: vote_valid[k] is a per-voter strobe with no ready
// back-pressure. A ballot is accepted only in COLLECT and only when voter k
// has not voted yet this session; any other strobe is silently dropped, so
// the first accepted ballot stands.
module voter_session
    import voter_pkg::*;
#(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_val,
    output logic                busy,
    output logic                done,
    output logic [2:0]          result,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    voted_cnt,
    output state_t              dbg_state
);

    localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t              state;
    logic [N_VOTERS-1:0] mask;
    logic [N_VOTERS-1:0] ballots;
    logic [TIMER_W-1:0]  timer;

    logic [N_VOTERS-1:0] take;
    logic [N_VOTERS-1:0] mask_next;
    logic [N_VOTERS-1:0] ballots_next;
    logic                close;

    logic [CNT_W-1:0]    tally_yes;
    logic [CNT_W-1:0]    tally_voted;
    logic [2:0]          tally_verdict;

    // Ballots accepted this cycle: only first-time voters. The close
    // decision and the tally both see this cycle's ballots, so a vote on
    // the timeout cycle is counted and the session closes exactly once.
    always_comb begin
        take         = vote_valid & ~mask;
        mask_next    = mask | take;
        ballots_next = ballots | (vote_val & take);
        close        = (&mask_next) || (timer == TIMER_LAST);
    end

    voter_tally #(
        .N_VOTERS (N_VOTERS),
        .CNT_W    (CNT_W)
    ) u_tally (
        .ballots   (ballots_next),
        .mask      (mask_next),
        .yes_cnt   (tally_yes),
        .voted_cnt (tally_voted),
        .verdict   (tally_verdict)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mask      <= '0;
            ballots   <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= RES_NONE;
            yes_cnt   <= '0;
            voted_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_COLLECT;
                        busy    <= 1'b1;
                        mask    <= '0;
                        ballots <= '0;
                        timer   <= '0;
                    end
                end
                ST_COLLECT: begin
                    mask    <= mask_next;
                    ballots <= ballots_next;
                    if (close) begin
                        // Verdict lands together with the done pulse.
                        state     <= ST_RESULT;
                        done      <= 1'b1;
                        result    <= tally_verdict;
                        yes_cnt   <= tally_yes;
                        voted_cnt <= tally_voted;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_RESULT: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_voter_session.sv
// tb_voter_session: randomized and directed sessions on a 4-voter and a
// 5-voter instance, checked against a per-voter reference model.
module tb_voter_session;
    import voter_pkg::*;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-voter instance ----------------
    logic       start4 = 1'b0;
    logic [3:0] vv4 = '0;
    logic [3:0] vl4 = '0;
    logic       busy4, done4;
    logic [2:0] res4;
    logic [2:0] yes4, voted4;
    state_t     dbg4;

    voter_session #(.N_VOTERS(4), .TIMEOUT(TO)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .vote_valid (vv4),
        .vote_val   (vl4),
        .busy       (busy4),
        .done       (done4),
        .result     (res4),
        .yes_cnt    (yes4),
        .voted_cnt  (voted4),
        .dbg_state  (dbg4)
    );

    // ---------------- 5-voter instance ----------------
    logic       start5 = 1'b0;
    logic [4:0] vv5 = '0;
    logic [4:0] vl5 = '0;
    logic       busy5, done5;
    logic [2:0] res5;
    logic [2:0] yes5, voted5;
    state_t     dbg5;

    voter_session #(.N_VOTERS(5), .TIMEOUT(TO)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start5),
        .vote_valid (vv5),
        .vote_val   (vl5),
        .busy       (busy5),
        .done       (done5),
        .result     (res5),
        .yes_cnt    (yes5),
        .voted_cnt  (voted5),
        .dbg_state  (dbg5)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    // Vote schedule for the 4-voter session: index i = i-th COLLECT cycle.
    logic [3:0] sv[TO];
    logic [3:0] sy[TO];

    // Verdict/counts of the last closed 4-voter session, from the model.
    logic [2:0] prev_res = RES_NONE;
    int         prev_yes = 0;
    int         prev_voted = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] verdict_of(input int y, input int n);
        if (2 * y < n)       return RES_REJECT;
        else if (2 * y == n) return RES_TIE;
        else                 return RES_ACCEPT;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < TO; i++) begin
            sv[i] = '0;
            sy[i] = '0;
        end
    endtask

    // ---------------- 4-voter driver + model ----------------
    // Model: each voter's first ballot within the session counts; the
    // session closes at the earlier of "last voter's first ballot" and the
    // final timeout cycle; done follows one cycle later.
    task automatic run_session4(input bit noise);
        int   first_idx[4];
        bit   yes_b[4];
        int   c, last, y, v;
        bit   all_in;
        logic [2:0] exp_res;

        for (int k = 0; k < 4; k++) begin
            first_idx[k] = -1;
            yes_b[k] = 1'b0;
        end
        for (int i = 0; i < TO; i++)
            for (int k = 0; k < 4; k++)
                if (first_idx[k] < 0 && sv[i][k]) begin
                    first_idx[k] = i;
                    yes_b[k] = sy[i][k];
                end
        c = TO - 1;
        all_in = 1'b1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            if (first_idx[k] < 0) all_in = 1'b0;
            else if (first_idx[k] > last) last = first_idx[k];
        end
        if (all_in && last < c) c = last;
        y = 0;
        v = 0;
        for (int k = 0; k < 4; k++)
            if (first_idx[k] >= 0 && first_idx[k] <= c) begin
                v++;
                if (yes_b[k]) y++;
            end
        exp_res = verdict_of(y, 4);

        // Idle cycle with stray votes that must be dropped.
        @(negedge clk);
        start4 = 1'b0;
        vv4 = 4'($urandom);
        vl4 = 4'($urandom);
        check("idle_busy", busy4, 0);

        // Start cycle t; votes here are still in IDLE and ignored.
        @(negedge clk);
        start4 = 1'b1;
        vv4 = 4'($urandom);
        vl4 = 4'($urandom);

        for (int p = 1; p <= c + 3; p++) begin
            @(negedge clk);
            check("done4", done4, (p == c + 2));
            check("busy4", busy4, (p <= c + 2));
            if (p == c + 2) begin
                check("result4", res4, exp_res);
                check("yes4", yes4, y);
                check("voted4", voted4, v);
                prev_res = exp_res;
                prev_yes = y;
                prev_voted = v;
            end else begin
                check("hold_result4", res4, prev_res);
                check("hold_yes4", yes4, prev_yes);
                check("hold_voted4", voted4, prev_voted);
            end
            // start noise only while the block is busy (COLLECT or RESULT)
            start4 = (noise && p <= c + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (p - 1 < TO) begin
                vv4 = sv[p-1];
                vl4 = sy[p-1];
            end else begin
                vv4 = 4'($urandom);
                vl4 = 4'($urandom);
            end
        end
        start4 = 1'b0;
        vv4 = '0;
        vl4 = '0;
    endtask

    // ---------------- 5-voter driver + model ----------------
    task automatic run_session5(input logic [4:0] yes_mask);
        int ny = 0;
        for (int k = 0; k < 5; k++) ny += int'(yes_mask[k]);
        @(negedge clk);
        start5 = 1'b1;
        vv5 = 5'($urandom);
        vl5 = 5'($urandom);
        @(negedge clk);
        start5 = 1'b0;
        vv5 = 5'b11111;
        vl5 = yes_mask;
        check("busy5", busy5, 1);
        check("done5_early", done5, 0);
        @(negedge clk);
        vv5 = 5'($urandom);
        vl5 = 5'($urandom);
        check("done5", done5, 1);
        check("result5", res5, verdict_of(ny, 5));
        check("yes5", yes5, ny);
        check("voted5", voted5, 5);
        @(negedge clk);
        vv5 = '0;
        vl5 = '0;
        check("done5_after", done5, 0);
        check("busy5_after", busy5, 0);
    endtask

    // One-cycle reset pulse in the middle of a 4-voter COLLECT phase.
    task automatic abort4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        vv4 = 4'b0011;
        vl4 = 4'b0001;
        check("abort_busy4", busy4, 1);
        @(negedge clk);
        vv4 = '0;
        check("abort_done4_a", done4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        check("abort_done4_b", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy4_rst", busy4, 0);
        check("abort_done4_rst", done4, 0);
        check("abort_res4_rst", res4, RES_NONE);
        check("abort_yes4_rst", yes4, 0);
        check("abort_voted4_rst", voted4, 0);
        prev_res = RES_NONE;
        prev_yes = 0;
        prev_voted = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle_done4", done4, 0);
            check("abort_idle_busy4", busy4, 0);
        end
    endtask

    task automatic abort5();
        @(negedge clk);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        vv5 = 5'b00111;
        vl5 = 5'b00111;
        @(negedge clk);
        vv5 = '0;
        rst_n = 1'b0;
        check("abort_done5", done5, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy5_rst", busy5, 0);
        check("abort_done5_rst", done5, 0);
        check("abort_res5_rst", res5, RES_NONE);
        check("abort_yes5_rst", yes5, 0);
        check("abort_voted5_rst", voted5, 0);
        @(negedge clk);
        check("abort_idle_done5", done5, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset held: every output at its reset value.
        repeat (3) @(negedge clk);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_res4", res4, RES_NONE);
        check("rst_yes4", yes4, 0);
        check("rst_voted4", voted4, 0);
        check("rst_busy5", busy5, 0);
        check("rst_done5", done5, 0);
        check("rst_res5", res5, RES_NONE);
        check("rst_yes5", yes5, 0);
        check("rst_voted5", voted5, 0);
        rst_n = 1'b1;

        // Verdict table: all 16 patterns cast in the first COLLECT cycle.
        for (int pat = 0; pat < 16; pat++) begin
            clear_sched();
            sv[0] = 4'b1111;
            sy[0] = 4'(pat);
            run_session4(1'b0);
        end

        // Timeout: only voter 0 votes yes, third COLLECT cycle.
        clear_sched();
        sv[2] = 4'b0001;
        sy[2] = 4'b0001;
        run_session4(1'b0);

        // No votes at all.
        clear_sched();
        run_session4(1'b0);

        // Duplicate ballots from voter 2; first (yes) stands.
        clear_sched();
        sv[0] = 4'b0100; sy[0] = 4'b0100;
        sv[1] = 4'b0100; sy[1] = 4'b0000;
        sv[2] = 4'b0100; sy[2] = 4'b0100;
        sv[3] = 4'b1011; sy[3] = 4'b0000;
        run_session4(1'b0);

        // Last voter votes on the timeout cycle.
        clear_sched();
        sv[0] = 4'b0111; sy[0] = 4'b0110;
        sv[TO-1] = 4'b1000; sy[TO-1] = 4'b1000;
        run_session4(1'b0);

        // Start pulses during COLLECT/RESULT must not open a session.
        clear_sched();
        sv[1] = 4'b0101; sy[1] = 4'b0101;
        run_session4(1'b1);

        // Abort mid-COLLECT, then a normal session.
        abort4();
        clear_sched();
        sv[0] = 4'b1100; sy[0] = 4'b1100;
        sv[4] = 4'b0011; sy[4] = 4'b0001;
        run_session4(1'b0);

        // Randomized sparse schedules with start noise.
        for (int s = 0; s < 30; s++) begin
            clear_sched();
            for (int i = 0; i < TO; i++) begin
                sv[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                sy[i] = 4'($urandom);
            end
            run_session4(1'b1);
        end

        // 5-voter instance: abort, then Y=2 / Y=3 and random patterns.
        abort5();
        run_session5(5'b00011);
        run_session5(5'b00111);
        for (int s = 0; s < 10; s++) run_session5(5'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voter_session.md
# voter_session

Parametrised, sequential successor to the 4-input combinational voter. It runs timed voting sessions for `N_VOTERS` voters and accepts at most one ballot per voter per session. A session closes when every voter has voted or the timeout expires. It then reports a registered one-hot verdict (reject / tie / accept) and the tallies. It sits between the voter input stage and the display/decision logic and replaces the fixed 4-voter lookup.

## Interface
- `N_VOTERS`, default 4: number of voters, ≥1.
- `TIMEOUT`, default 16: maximum COLLECT cycles per session, ≥1.
- `CNT_W`, default `$clog2(N_VOTERS+1)`: tally width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  opens a session; honoured only in IDLE.
- `vote_valid`  in  N_VOTERS  bit k high means voter k casts a ballot this cycle.
- `vote_val`  in  N_VOTERS  bit k is voter k's ballot (1 = yes), sampled when `vote_valid[k]` is high.
- `busy`  out  1  high in COLLECT and RESULT.
- `done`  out  1  one-cycle pulse in RESULT.
- `result`  out  3  one-hot verdict: `[2]` reject, `[1]` tie, `[0]` accept.
- `yes_cnt`  out  CNT_W  yes ballots in the last closed session.
- `voted_cnt`  out  CNT_W  ballots cast in the last closed session.

## Operation
- States:
  - IDLE: on `start`, go to COLLECT.
  - COLLECT: go to RESULT on the close condition.
  - RESULT: go to IDLE unconditionally after one cycle.
- Entering COLLECT clears the voted mask, the ballot register and the timer. `result`, `yes_cnt` and `voted_cnt` keep their previous values until the next RESULT.
- In COLLECT, for each k with `vote_valid[k]` high and voted-mask bit k clear: set mask bit k and latch `vote_val[k]`.
  - Repeat ballots from a voter are ignored; the first ballot stands.
  - Any number of voters may vote in the same cycle.
- Close condition is evaluated on the mask including this cycle's ballots: (mask all ones) OR (timer == TIMEOUT-1). If both are true in the same cycle, the session closes once.
- Verdict is computed on entry to RESULT. Absent voters count as "no". With Y = popcount(yes ballots):
  - 2Y < N_VOTERS: reject, `result = 3'b100`.
  - 2Y == N_VOTERS: tie, `result = 3'b010`.
  - 2Y > N_VOTERS: accept, `result = 3'b001`.
  - For N_VOTERS = 4 this reproduces the legacy 4-input truth table.
- `vote_valid` outside COLLECT is ignored. `start` outside IDLE is ignored, including in the RESULT cycle.
- Tally arithmetic is unsigned, width CNT_W. The comparison 2Y vs N_VOTERS is done at CNT_W+1 bits, so there is no overflow.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `result` 3'b000, `yes_cnt` 0, `voted_cnt` 0; mask, ballots and timer 0.
- Reset mid-session aborts the session with no `done` pulse and returns every output to its reset value.
- `start` high at cycle t: COLLECT during cycles t+1 … , and `busy` is high from t+1.
- Close at cycle c (all voted, or timeout): RESULT at c+1, with `done` = 1 and `result`/counts valid in the same cycle. IDLE at c+2, where `busy` = 0 and outputs are held.
- Fastest session: all votes at t+1, `done` at t+2.
- No-vote session: COLLECT for exactly TIMEOUT cycles, `done` at t+TIMEOUT+1.
- The earliest next `start` that is accepted is in the first IDLE cycle (c+2).

## Structure
- Shared package `voter_pkg`:
  - state enum (IDLE, COLLECT, RESULT);
  - result constants RES_REJECT = 3'b100, RES_TIE = 3'b010, RES_ACCEPT = 3'b001, RES_NONE = 3'b000.
- Sub-module `voter_tally`: purely combinational, parametrised on N_VOTERS.
  - Inputs: ballot vector and mask.
  - Outputs: popcount Y, popcount of the mask, and the one-hot verdict.
  - It is the generalised replacement for the legacy case-table voter.
- Top level holds the FSM, timer, mask/ballot registers and output registers.

## Test plan
- Reset and verdict table:
  - Reset held → all outputs 0.
  - Then, with N=4, sweep all 16 ballot patterns, each cast in the first COLLECT cycle. Expect `done` at t+2, 0–1 yes → 100, 2 yes → 010, 3–4 yes → 001, and `voted_cnt` = 4.
- Timeout, TIMEOUT=16:
  - Only voter 0 votes yes, at t+3 → `done` at t+17, `result` 100, `yes_cnt` 1, `voted_cnt` 1.
  - No votes at all → `done` at t+17, `result` 100, `voted_cnt` 0.
- Duplicate ballots: voter 2 votes yes, then no, then yes again → only the first counts. Voters 0, 1, 3 then vote no → `yes_cnt` 1, `result` 100.
- Simultaneous close: the last voter votes on the timeout cycle → exactly one `done` pulse, and the last vote is counted.
- Ignored inputs:
  - `start` during COLLECT and during RESULT → no new session.
  - Votes in IDLE → not counted.
  - Outputs hold the previous verdict until the next `done`.
- Abort: `rst_n` low for one cycle mid-COLLECT → no `done`, outputs 0. A new `start` then runs a normal session. Repeat with N_VOTERS=5: Y=2 → 100, Y=3 → 001.
